// File: rtl/alu_muldiv_if.sv
// Handshake and result bundle between the pipeline controller and the
// iterative multiply/divide unit.
interface alu_muldiv_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  // Controller side: issues requests, watches busy/done and reads HI/LO.
  modport master (
    output start, op, a, b,
    input  busy, done, div_zero, hi, lo
  );

  // Unit side: accepts requests and owns HI/LO.
  modport slave (
    input  start, op, a, b,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/alu_muldiv.sv
// Iterative multiply/divide unit with HI/LO registers.
// Multiply is shift-add and divide is restoring, one bit per clock.
// Both work on operand magnitudes; signs are reapplied in FIX.
module alu_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic       clk,
  input  logic       reset_n,
  alu_muldiv_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  logic [1:0]       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             is_div_reg;
  logic             neg_q_reg;   // negate product / quotient
  logic             neg_r_reg;   // negate remainder (dividend was negative)
  logic             zero_reg;    // divide by zero, skip the datapath
  logic [WIDTH-1:0] opb_reg;     // multiplicand or divisor magnitude
  logic [WIDTH-1:0] acc_reg;     // upper product half or partial remainder
  logic [WIDTH-1:0] sh_reg;      // multiplier->lower product, dividend->quotient
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             dz_reg;

  logic             signed_op;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ok;
  logic [WIDTH-1:0] div_sub;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quot_fix;
  logic [WIDTH-1:0] rem_fix;

  // Operand decode at issue: signed ops (MULT, DIV) have op[0]==0.
  always_comb begin
    signed_op = ~bus.op[0];
    a_neg     = signed_op & bus.a[WIDTH-1];
    b_neg     = signed_op & bus.b[WIDTH-1];
    a_mag     = a_neg ? -bus.a : bus.a;
    b_mag     = b_neg ? -bus.b : bus.b;
  end

  // One iteration of each algorithm, plus the final sign correction.
  always_comb begin
    mul_sum   = {1'b0, acc_reg} + (sh_reg[0] ? {1'b0, opb_reg} : '0);
    div_shift = {acc_reg, sh_reg[WIDTH-1]};
    div_ok    = (div_shift >= {1'b0, opb_reg});
    // The remainder after a successful subtract is below the divisor, so
    // the low WIDTH bits of the difference are exact.
    div_sub   = div_shift[WIDTH-1:0] - opb_reg;
    prod      = {acc_reg, sh_reg};
    prod_fix  = neg_q_reg ? -prod : prod;
    quot_fix  = neg_q_reg ? -sh_reg : sh_reg;
    rem_fix   = neg_r_reg ? -acc_reg : acc_reg;
  end

  // Control FSM, iteration datapath and HI/LO registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= '0;
      is_div_reg <= 1'b0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      zero_reg   <= 1'b0;
      opb_reg    <= '0;
      acc_reg    <= '0;
      sh_reg     <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      dz_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      dz_reg   <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (bus.start) begin
            case (bus.op)
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                is_div_reg <= bus.op[1];
                neg_q_reg  <= a_neg ^ b_neg;
                neg_r_reg  <= a_neg;
                opb_reg    <= b_mag;
                sh_reg     <= a_mag;
                acc_reg    <= '0;
                cnt_reg    <= '0;
                busy_reg   <= 1'b1;
                if (bus.op[1] && (bus.b == '0)) begin
                  zero_reg  <= 1'b1;
                  state_reg <= S_FIX;
                end else begin
                  zero_reg  <= 1'b0;
                  state_reg <= S_RUN;
                end
              end
              OP_MTHI: hi_reg <= bus.a;
              OP_MTLO: lo_reg <= bus.a;
              default: ;
            endcase
          end
        end
        S_RUN: begin
          if (is_div_reg) begin
            acc_reg <= div_ok ? div_sub : div_shift[WIDTH-1:0];
            sh_reg  <= {sh_reg[WIDTH-2:0], div_ok};
          end else begin
            acc_reg <= mul_sum[WIDTH:1];
            sh_reg  <= {mul_sum[0], sh_reg[WIDTH-1:1]};
          end
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == CNT_W'(WIDTH - 1)) begin
            state_reg <= S_FIX;
          end
        end
        S_FIX: begin
          if (!zero_reg) begin
            if (is_div_reg) begin
              hi_reg <= rem_fix;
              lo_reg <= quot_fix;
            end else begin
              hi_reg <= prod_fix[2*WIDTH-1:WIDTH];
              lo_reg <= prod_fix[WIDTH-1:0];
            end
          end
          done_reg  <= 1'b1;
          dz_reg    <= zero_reg;
          busy_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_reg;
  assign bus.done     = done_reg;
  assign bus.div_zero = dz_reg;
  assign bus.hi       = hi_reg;
  assign bus.lo       = lo_reg;

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv with a scoreboard of expected HI/LO results.
module tb_alu_muldiv;
  localparam int W = 32;

  localparam logic [2:0] MULT  = 3'b000;
  localparam logic [2:0] MULTU = 3'b001;
  localparam logic [2:0] DIV   = 3'b010;
  localparam logic [2:0] DIVU  = 3'b011;
  localparam logic [2:0] MTHI  = 3'b100;
  localparam logic [2:0] MTLO  = 3'b101;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  alu_muldiv_if #(.WIDTH(W)) bus ();

  alu_muldiv #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  exp_t         sb[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  logic [W-1:0] cur_hi   = '0;
  logic [W-1:0] cur_lo   = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_op(input logic [W-1:0] hi, input logic [W-1:0] lo,
                           input logic dz, input int lat);
    exp_t e;
    e.hi = hi; e.lo = lo; e.dz = dz; e.lat = lat;
    sb.push_back(e);
  endtask

  // Drive a request at the current negedge, held across one rising edge.
  task automatic issue_now(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    issue_now(op, a, b);
  endtask

  // Wait for done (bounded), then pop the scoreboard and compare.
  // k counts negedges since the start edge; k0 is where the caller already is.
  task automatic wait_result(input string tag, input int k0);
    int   k = k0;
    int   busy_cnt = 0;
    bit   seen = 1'b0;
    exp_t e;
    while (k < 200) begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      if (k == 5) begin
        check({tag, " hold hi"}, bus.hi, cur_hi);
        check({tag, " hold lo"}, bus.lo, cur_lo);
      end
      @(negedge clk);
      k++;
    end
    n_checks++;
    assert (seen) else begin
      n_fail++;
      $error("FAIL %s timeout: observed no done, expected done", tag);
    end
    e = sb.pop_front();
    if (seen) begin
      check({tag, " latency"}, 64'(k), 64'(e.lat));
      check({tag, " busy cycles"}, 64'(busy_cnt), 64'(e.lat - k0));
      check({tag, " hi"}, bus.hi, e.hi);
      check({tag, " lo"}, bus.lo, e.lo);
      check({tag, " div_zero"}, bus.div_zero, e.dz);
    end
    cur_hi = e.hi;
    cur_lo = e.lo;
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] hi, input logic [W-1:0] lo,
                        input logic dz, input int lat);
    expect_op(hi, lo, dz, lat);
    issue(op, a, b);
    wait_result(tag, 0);
  endtask

  task automatic check_pulse_end(input string tag);
    @(negedge clk);
    check({tag, " done low"}, bus.done, 1'b0);
    check({tag, " div_zero low"}, bus.div_zero, 1'b0);
    check({tag, " busy low"}, bus.busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
    repeat (3) @(negedge clk);
    check("reset busy", bus.busy, 1'b0);
    check("reset done", bus.done, 1'b0);
    check("reset div_zero", bus.div_zero, 1'b0);
    check("reset hi", bus.hi, '0);
    check("reset lo", bus.lo, '0);
    reset_n = 1'b1;

    run_op("multu max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33);
    check_pulse_end("multu max");
    run_op("mult -3*7", MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33);
    run_op("mult min*min", MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0, 33);
    run_op("div -7/2", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33);
    run_op("divu 100/7", DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33);
    run_op("div min/-1", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 33);

    // MTHI writes immediately with no busy; divide by zero keeps HI/LO.
    issue(MTHI, 32'h1234_5678, 32'h0);
    check("mthi hi", bus.hi, 32'h1234_5678);
    check("mthi busy", bus.busy, 1'b0);
    cur_hi = 32'h1234_5678;
    run_op("divu by zero", DIVU, 32'd55, 32'd0, 32'h1234_5678, 32'h8000_0000, 1'b1, 1);
    check_pulse_end("divu by zero");

    // Undefined op is ignored.
    issue(3'b110, 32'hFFFF_FFFF, 32'd1);
    check("undef busy", bus.busy, 1'b0);
    check("undef hi", bus.hi, cur_hi);
    check("undef lo", bus.lo, cur_lo);

    // Requests while busy are ignored, then a start in the done cycle is taken.
    expect_op(32'h0, 32'd15, 1'b0, 33);
    issue(MULTU, 32'd3, 32'd5);
    issue_now(MTLO, 32'hDEAD_BEEF, 32'h0);
    issue_now(MULTU, 32'd7, 32'd7);
    wait_result("busy ignore", 2);
    expect_op(32'd10, 32'd30, 1'b0, 33);
    issue_now(DIVU, 32'd1000, 32'd33);
    check("back2back busy", bus.busy, 1'b1);
    wait_result("back2back", 0);

    // Asynchronous reset in the middle of a divide.
    issue(DIV, 32'hFFFF_FF00, 32'd3);
    repeat (10) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("midreset busy", bus.busy, 1'b0);
    check("midreset done", bus.done, 1'b0);
    check("midreset div_zero", bus.div_zero, 1'b0);
    check("midreset hi", bus.hi, '0);
    check("midreset lo", bus.lo, '0);
    cur_hi = '0;
    cur_lo = '0;
    @(negedge clk);
    reset_n = 1'b1;
    run_op("divu 9/3", DIVU, 32'd9, 32'd3, 32'd0, 32'd3, 1'b0, 33);
    check_pulse_end("divu 9/3");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
